// File: rtl/spartan_fifo_arb.sv
// spartan_fifo_arb: four-source round-robin, packet-locked arbiter driving one FIFO write port
module spartan_fifo_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    rst_in,
    input  logic [4*DATA_WIDTH-1:0] SRC_DIN,
    input  logic [3:0]              SRC_LAST,
    input  logic [3:0]              SRC_VAL,
    output logic [3:0]              SRC_RDY,
    output logic [DATA_WIDTH-1:0]   DOUT,
    output logic                    DOUT_LAST,
    output logic [1:0]              DOUT_SRC,
    output logic                    DOUT_VAL,
    input  logic                    DOUT_RDY
);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state, state_nxt;
    logic [1:0] gnt, gnt_nxt, rr_ptr, rr_nxt, sel, src;
    logic ld, grant, acc;

    // Scan downward so the valid source closest to rr_ptr wins.
    always_comb begin
        sel = rr_ptr;
        for (int i = 3; i >= 0; i--)
            if (SRC_VAL[rr_ptr + 2'(i)]) sel = rr_ptr + 2'(i);
    end

    assign ld      = !DOUT_VAL || DOUT_RDY;
    assign src     = (state == LOCK) ? gnt : sel;
    assign grant   = !rst_in && ld && (state == LOCK || |SRC_VAL);
    assign acc     = grant && SRC_VAL[src];
    assign SRC_RDY = grant ? 4'b0001 << src : 4'b0000;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr_ptr;
        if (acc) begin
            state_nxt = SRC_LAST[src] ? IDLE : LOCK;
            gnt_nxt   = SRC_LAST[src] ? gnt : src;
            rr_nxt    = SRC_LAST[src] ? src + 2'd1 : rr_ptr;
        end
    end

    always_ff @(posedge CLK or posedge rst_in) begin
        if (rst_in) begin
            state  <= IDLE;
            gnt    <= 2'd0;
            rr_ptr <= 2'd0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    always_ff @(posedge CLK or posedge rst_in) begin
        if (rst_in) begin
            DOUT      <= '0;
            DOUT_LAST <= 1'b0;
            DOUT_SRC  <= 2'd0;
            DOUT_VAL  <= 1'b0;
        end else if (acc) begin
            DOUT      <= SRC_DIN[src*DATA_WIDTH +: DATA_WIDTH];
            DOUT_LAST <= SRC_LAST[src];
            DOUT_SRC  <= src;
            DOUT_VAL  <= 1'b1;
        end else if (DOUT_RDY) begin
            DOUT_VAL  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spartan_fifo_arb.sv
// tb_spartan_fifo_arb: randomized scoreboard bench for the packet-locked FIFO arbiter
module tb_spartan_fifo_arb;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          rst_in = 1'b1;
    logic [4*DW-1:0] SRC_DIN;
    logic [3:0]    SRC_LAST, SRC_VAL, SRC_RDY;
    logic [DW-1:0] DOUT;
    logic          DOUT_LAST, DOUT_VAL, DOUT_RDY;
    logic [1:0]    DOUT_SRC;

    spartan_fifo_arb #(.DATA_WIDTH(DW)) u_dut (
        .CLK(CLK), .rst_in(rst_in), .SRC_DIN(SRC_DIN), .SRC_LAST(SRC_LAST),
        .SRC_VAL(SRC_VAL), .SRC_RDY(SRC_RDY), .DOUT(DOUT), .DOUT_LAST(DOUT_LAST),
        .DOUT_SRC(DOUT_SRC), .DOUT_VAL(DOUT_VAL), .DOUT_RDY(DOUT_RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    idx;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0, failures = 0;
    int p_val[4], p_rdy, len_lo, len_hi;
    int left[4];
    logic [DW-1:0] cur[4];
    bit seq_mode;
    bit m_lock, m_val;
    int m_gnt, m_ptr;
    bit hold;
    beat_t held, got, want;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic new_pkt(input int n);
        left[n] = $urandom_range(len_hi, len_lo);
        cur[n]  = seq_mode ? cur[n] + 1 : $urandom;
    endtask

    task automatic model_reset();
        m_lock = 0; m_val = 0; m_gnt = 0; m_ptr = 0;
        exp_q.delete();
        for (int n = 0; n < 4; n++) new_pkt(n);
    endtask

    task automatic drive();
        for (int n = 0; n < 4; n++) begin
            SRC_VAL[n]            = $urandom_range(99, 0) < p_val[n];
            SRC_DIN[n*DW +: DW]   = cur[n];
            SRC_LAST[n]           = left[n] == 1;
        end
        DOUT_RDY = $urandom_range(99, 0) < p_rdy;
    endtask

    // Reference: lock to one source per packet, otherwise first valid source from the pointer.
    task automatic step();
        bit ld, rb, acc, found;
        int src;
        logic [3:0] e;
        ld = !m_val || DOUT_RDY;
        src = m_gnt;
        rb = ld;
        if (!m_lock) begin
            found = 0;
            for (int k = 0; k < 4; k++)
                if (!found && SRC_VAL[(m_ptr + k) % 4]) begin
                    src = (m_ptr + k) % 4;
                    found = 1;
                end
            rb = ld && found;
        end
        #1;
        e = rb ? 4'b0001 << src : 4'b0000;
        check("src_rdy", SRC_RDY, e);
        acc = rb && SRC_VAL[src];
        if (acc) begin
            exp_q.push_back('{data: cur[src], last: SRC_LAST[src], idx: 2'(src)});
            if (left[src] == 1) begin
                m_lock = 0;
                m_ptr = (src + 1) % 4;
                new_pkt(src);
            end else begin
                m_lock = 1;
                m_gnt = src;
                left[src]--;
                cur[src] = seq_mode ? cur[src] + 1 : $urandom;
            end
        end
        m_val = acc || (m_val && !DOUT_RDY);
        @(negedge CLK);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            drive();
            step();
        end
    endtask

    task automatic set_val(input int a, input int b, input int c, input int d);
        p_val[0] = a; p_val[1] = b; p_val[2] = c; p_val[3] = d;
    endtask

    task automatic mid_reset();
        drive();
        #2;
        rst_in = 1'b1;
        #1;
        check("rst_async_val", DOUT_VAL, 0);
        check("rst_async_rdy", SRC_RDY, 0);
        repeat (2) @(negedge CLK);
        rst_in = 1'b0;
        model_reset();
    endtask

    always @(negedge CLK) begin
        #3;
        if (rst_in) begin
            hold = 0;
        end else begin
            got = {DOUT, DOUT_LAST, DOUT_SRC};
            if (hold) check("hold_stable", got, held);
            if (DOUT_VAL && DOUT_RDY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_extra: got %0h expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    check("beat", got, want);
                end
            end
            hold = DOUT_VAL && !DOUT_RDY;
            held = got;
        end
    end

    initial begin
        SRC_VAL = 4'hF; SRC_LAST = 4'h0; SRC_DIN = '0; DOUT_RDY = 1'b0;
        hold = 0;
        seq_mode = 1;
        len_lo = 4; len_hi = 4; p_rdy = 100;
        set_val(100, 0, 0, 0);
        @(posedge CLK);
        #1;
        check("rst_dout_val", DOUT_VAL, 0);
        check("rst_dout", DOUT, 0);
        check("rst_dout_last", DOUT_LAST, 0);
        check("rst_dout_src", DOUT_SRC, 0);
        check("rst_src_rdy", SRC_RDY, 0);
        @(negedge CLK);
        rst_in = 1'b0;
        model_reset();
        cur[0] = 32'h10; left[0] = 4;
        cycles(5);
        check("single_rr_ptr", u_dut.rr_ptr, 1);

        seq_mode = 0;
        len_lo = 1; len_hi = 1;
        set_val(100, 100, 100, 100);
        cycles(20);

        len_lo = 3; len_hi = 3;
        set_val(0, 0, 100, 0);
        cycles(2);
        set_val(100, 0, 100, 0);
        cycles(6);

        len_lo = 4; len_hi = 4;
        set_val(100, 100, 100, 100);
        cycles(6);
        p_rdy = 0;
        cycles(5);
        p_rdy = 100;
        cycles(8);

        set_val(100, 100, 100, 100);
        cycles(1);
        set_val(0, 100, 100, 100);
        cycles(1);
        set_val(100, 100, 100, 100);
        cycles(1);
        set_val(30, 30, 100, 100);
        cycles(40);

        len_lo = 1; len_hi = 4;
        set_val(70, 70, 70, 70);
        p_rdy = 70;
        cycles(1500);

        len_lo = 4; len_hi = 4;
        set_val(100, 100, 100, 100);
        p_rdy = 100;
        mid_reset();
        cycles(1);
        mid_reset();
        set_val(0, 100, 0, 100);
        cycles(6);

        len_lo = 1; len_hi = 5;
        set_val(60, 90, 40, 80);
        p_rdy = 60;
        cycles(1500);

        set_val(0, 0, 0, 0);
        p_rdy = 100;
        cycles(4);
        check("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
